// File: rtl/regfile_wb_forward.sv
// regfile_wb_forward
//   Sits between the EX/MEM stages and the RegisterFile. It carries EX results
//   through internal MEM and WB pipeline registers and drives the RegisterFile
//   write port (RW/PW/LE) from the WB stage. It also resolves RAW hazards on the
//   decode operands by forwarding (EX > MEM > WB > register file), raises a
//   one-cycle load-use stall, and counts stall cycles.
//
//   Ports
//     Clk, Reset          clock and synchronous active-high reset
//     ex_rd/ex_we/        EX-stage destination, write enable, load flag, ALU result
//     ex_is_load/ex_result
//     mem_load_data       load data, valid while the load occupies MEM
//     id_rs, id_rt        decode source register addresses
//     PA, PB              register file read data for RA/RB
//     RA, RB              register file read addresses (id_rs/id_rt, combinational)
//     fwd_a, fwd_b        forwarded operand values (combinational)
//     stall               load-use hazard (combinational)
//     RW, PW, LE          register file write port (registered)
//     stall_count         saturating count of stall cycles since reset
module regfile_wb_forward #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] ex_rd,
   input  logic              ex_we,
   input  logic              ex_is_load,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [DATA_W-1:0] mem_load_data,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic [DATA_W-1:0] PA,
   input  logic [DATA_W-1:0] PB,
   output logic [ADDR_W-1:0] RA,
   output logic [ADDR_W-1:0] RB,
   output logic [DATA_W-1:0] fwd_a,
   output logic [DATA_W-1:0] fwd_b,
   output logic              stall,
   output logic [ADDR_W-1:0] RW,
   output logic [DATA_W-1:0] PW,
   output logic              LE,
   output logic [CNT_W-1:0]  stall_count
);

   // MEM stage registers; mem_we_q doubles as the MEM valid bit
   logic [ADDR_W-1:0] mem_rd_q, mem_rd_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_is_load_q, mem_is_load_d;
   logic [DATA_W-1:0] mem_result_q, mem_result_d;

   // WB stage registers, which are the register file write port
   logic [ADDR_W-1:0] rw_q, rw_d;
   logic [DATA_W-1:0] pw_q, pw_d;
   logic              le_q, le_d;

   logic [CNT_W-1:0]  stall_count_q, stall_count_d;

   logic [DATA_W-1:0] mem_val_s;
   logic              ex_fwd_ok_s;

   assign RA          = id_rs;
   assign RB          = id_rt;
   assign RW          = rw_q;
   assign PW          = pw_q;
   assign LE          = le_q;
   assign stall_count = stall_count_q;

   // Value the MEM-stage instruction will write, and EX forwarding eligibility
   always_comb begin
      mem_val_s   = mem_is_load_q ? mem_load_data : mem_result_q;
      // A load in EX has no data yet; the stall covers that case instead.
      ex_fwd_ok_s = ex_we && !ex_is_load;
   end

   // Load-use hazard detection; r0 never stalls
   always_comb begin
      stall = 1'b0;
      if (ex_we && ex_is_load && (ex_rd != '0) &&
          ((ex_rd == id_rs) || (ex_rd == id_rt))) begin
         stall = 1'b1;
      end else begin
         stall = 1'b0;
      end
   end

   // Operand A forwarding mux, youngest producer first
   always_comb begin
      fwd_a = PA;
      if (id_rs == '0) begin
         fwd_a = PA;
      end else if (ex_fwd_ok_s && (ex_rd == id_rs)) begin
         fwd_a = ex_result;
      end else if (mem_we_q && (mem_rd_q == id_rs)) begin
         fwd_a = mem_val_s;
      end else if (le_q && (rw_q == id_rs)) begin
         fwd_a = pw_q;
      end else begin
         fwd_a = PA;
      end
   end

   // Operand B forwarding mux, youngest producer first
   always_comb begin
      fwd_b = PB;
      if (id_rt == '0) begin
         fwd_b = PB;
      end else if (ex_fwd_ok_s && (ex_rd == id_rt)) begin
         fwd_b = ex_result;
      end else if (mem_we_q && (mem_rd_q == id_rt)) begin
         fwd_b = mem_val_s;
      end else if (le_q && (rw_q == id_rt)) begin
         fwd_b = pw_q;
      end else begin
         fwd_b = PB;
      end
   end

   // Next-state for the MEM/WB pipeline and the saturating stall counter
   always_comb begin
      mem_rd_d      = ex_rd;
      mem_we_d      = ex_we;
      mem_is_load_d = ex_is_load;
      mem_result_d  = ex_result;
      rw_d          = mem_rd_q;
      pw_d          = mem_val_s;
      le_d          = mem_we_q && (mem_rd_q != '0);
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end else begin
         stall_count_d = stall_count_q;
      end
   end

   // State registers; reset drops any in-flight MEM/WB write
   always_ff @(posedge Clk) begin
      if (Reset) begin
         mem_rd_q      <= '0;
         mem_we_q      <= 1'b0;
         mem_is_load_q <= 1'b0;
         mem_result_q  <= '0;
         rw_q          <= '0;
         pw_q          <= '0;
         le_q          <= 1'b0;
         stall_count_q <= '0;
      end else begin
         mem_rd_q      <= mem_rd_d;
         mem_we_q      <= mem_we_d;
         mem_is_load_q <= mem_is_load_d;
         mem_result_q  <= mem_result_d;
         rw_q          <= rw_d;
         pw_q          <= pw_d;
         le_q          <= le_d;
         stall_count_q <= stall_count_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_forward.sv
// tb_regfile_wb_forward
//   Directed-vector bench for regfile_wb_forward. A second instance with a
//   4-bit stall counter shares all inputs so saturation can be reached quickly.
module tb_regfile_wb_forward;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              Clk;
   logic              Reset;
   logic [ADDR_W-1:0] ex_rd;
   logic              ex_we;
   logic              ex_is_load;
   logic [DATA_W-1:0] ex_result;
   logic [DATA_W-1:0] mem_load_data;
   logic [ADDR_W-1:0] id_rs, id_rt;
   logic [DATA_W-1:0] PA, PB;
   logic [ADDR_W-1:0] RA, RB, RW;
   logic [DATA_W-1:0] fwd_a, fwd_b, PW;
   logic              stall, LE;
   logic [15:0]       stall_count;

   logic [ADDR_W-1:0] s_ra, s_rb, s_rw;
   logic [DATA_W-1:0] s_fwd_a, s_fwd_b, s_pw;
   logic              s_stall, s_le;
   logic [3:0]        s_count;

   int vectors;
   int miscompares;

   regfile_wb_forward #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
      .ex_result(ex_result), .mem_load_data(mem_load_data), .id_rs(id_rs), .id_rt(id_rt),
      .PA(PA), .PB(PB), .RA(RA), .RB(RB), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
      .RW(RW), .PW(PW), .LE(LE), .stall_count(stall_count)
   );

   regfile_wb_forward #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut_sat (
      .Clk(Clk), .Reset(Reset), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
      .ex_result(ex_result), .mem_load_data(mem_load_data), .id_rs(id_rs), .id_rt(id_rt),
      .PA(PA), .PB(PB), .RA(s_ra), .RB(s_rb), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall),
      .RW(s_rw), .PW(s_pw), .LE(s_le), .stall_count(s_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // advance one rising edge, then settle 1 time unit past it
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // EX bubble; decode addresses and read data left unchanged
   task automatic bubble();
      ex_we      = 1'b0;
      ex_is_load = 1'b0;
      ex_rd      = 5'd0;
      ex_result  = 32'h0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      ex_rd = 5'($urandom); ex_we = 1'($urandom); ex_is_load = 1'($urandom);
      ex_result = $urandom; mem_load_data = $urandom;
      id_rs = 5'($urandom); id_rt = 5'($urandom); PA = $urandom; PB = $urandom;
      tick();
      ex_rd = 5'($urandom); ex_we = 1'b1; ex_result = $urandom;
      tick();
      vectors++;
      if (LE !== 1'b0 || RW !== 5'd0 || PW !== 32'h0 || stall_count !== 16'd0 || s_count !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_state: LE=%b RW=%0d PW=%h cnt=%0d sat_cnt=%0d, required all 0", LE, RW, PW, stall_count, s_count);
      end
      bubble();
      id_rs = 5'd0; id_rt = 5'd0; PA = 32'h0; PB = 32'h0;
      Reset = 1'b0;
      // put a write to r3 into MEM, then reset while it is in flight
      ex_we = 1'b1; ex_rd = 5'd3; ex_result = 32'h33;
      tick();
      bubble();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (LE !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drop_inflight: cycle %0d LE=%b, required 0", i, LE);
         end
         tick();
      end
   endtask

   task automatic test_single_write();
      bubble();
      ex_we = 1'b1; ex_rd = 5'd5; ex_result = 32'h14;
      tick();
      bubble();
      vectors++;
      if (LE !== 1'b0) begin
         miscompares++;
         $display("FAIL write_t1: LE=%b, required 0", LE);
      end
      tick();
      vectors++;
      if (LE !== 1'b1 || RW !== 5'd5 || PW !== 32'h14) begin
         miscompares++;
         $display("FAIL write_t2: LE=%b RW=%0d PW=%h, required LE=1 RW=5 PW=00000014", LE, RW, PW);
      end
      tick();
      vectors++;
      if (LE !== 1'b0) begin
         miscompares++;
         $display("FAIL write_t3: LE=%b, required 0", LE);
      end
   endtask

   task automatic test_forward_chain();
      id_rs = 5'd7; PA = 32'h99;
      ex_we = 1'b1; ex_rd = 5'd7; ex_result = 32'h1;
      #1;
      vectors++;
      if (fwd_a !== 32'h1) begin
         miscompares++;
         $display("FAIL fwd_ex_only: fwd_a=%h, required 00000001", fwd_a);
      end
      tick();
      ex_result = 32'h2;
      tick();
      ex_result = 32'h3;
      #1;
      vectors++;
      if (fwd_a !== 32'h3) begin
         miscompares++;
         $display("FAIL fwd_ex_mem_wb: fwd_a=%h, required 00000003", fwd_a);
      end
      tick();
      bubble();
      #1;
      vectors++;
      if (fwd_a !== 32'h3) begin
         miscompares++;
         $display("FAIL fwd_mem: fwd_a=%h, required 00000003", fwd_a);
      end
      tick();
      vectors++;
      if (fwd_a !== 32'h3 || LE !== 1'b1 || RW !== 5'd7 || PW !== 32'h3) begin
         miscompares++;
         $display("FAIL fwd_wb: fwd_a=%h LE=%b RW=%0d PW=%h, required fwd_a=3 LE=1 RW=7 PW=3", fwd_a, LE, RW, PW);
      end
      tick();
      vectors++;
      if (fwd_a !== 32'h99) begin
         miscompares++;
         $display("FAIL fwd_regfile: fwd_a=%h, required 00000099", fwd_a);
      end
   endtask

   task automatic test_load_use();
      bubble();
      id_rs = 5'd0; PA = 32'h0;
      id_rt = 5'd9; PB = 32'h77;
      ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; ex_result = 32'h55;
      #1;
      vectors++;
      if (stall !== 1'b1 || fwd_b !== 32'h77 || stall_count !== 16'd0) begin
         miscompares++;
         $display("FAIL load_use_stall: stall=%b fwd_b=%h cnt=%0d, required stall=1 fwd_b=00000077 cnt=0", stall, fwd_b, stall_count);
      end
      tick();
      bubble();
      mem_load_data = 32'hDEADBEEF;
      #1;
      vectors++;
      if (stall !== 1'b0 || fwd_b !== 32'hDEADBEEF || stall_count !== 16'd1) begin
         miscompares++;
         $display("FAIL load_fwd_mem: stall=%b fwd_b=%h cnt=%0d, required stall=0 fwd_b=deadbeef cnt=1", stall, fwd_b, stall_count);
      end
      tick();
      mem_load_data = 32'h0;
      vectors++;
      if (LE !== 1'b1 || RW !== 5'd9 || PW !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL load_writeback: LE=%b RW=%0d PW=%h, required LE=1 RW=9 PW=deadbeef", LE, RW, PW);
      end
      tick();
   endtask

   task automatic test_r0();
      id_rt = 5'd0; PB = 32'h0;
      id_rs = 5'd0; PA = 32'h0;
      ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; ex_result = 32'h1234;
      mem_load_data = 32'hAAAA5555;
      #1;
      vectors++;
      if (stall !== 1'b0 || fwd_a !== 32'h0) begin
         miscompares++;
         $display("FAIL r0_no_stall: stall=%b fwd_a=%h, required stall=0 fwd_a=0", stall, fwd_a);
      end
      tick();
      bubble();
      #1;
      vectors++;
      if (fwd_a !== 32'h0) begin
         miscompares++;
         $display("FAIL r0_no_mem_fwd: fwd_a=%h, required 0", fwd_a);
      end
      tick();
      vectors++;
      if (LE !== 1'b0 || stall_count !== 16'd1) begin
         miscompares++;
         $display("FAIL r0_no_write: LE=%b cnt=%0d, required LE=0 cnt=1", LE, stall_count);
      end
      mem_load_data = 32'h0;
      tick();
   endtask

   task automatic test_same_operands();
      id_rs = 5'd6; id_rt = 5'd6; PA = 32'h10; PB = 32'h10;
      ex_we = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd6; ex_result = 32'hCAFE;
      #1;
      vectors++;
      if (fwd_a !== 32'hCAFE || fwd_b !== 32'hCAFE || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL same_rs_rt_fwd: fwd_a=%h fwd_b=%h stall=%b, required cafe cafe 0", fwd_a, fwd_b, stall);
      end
      ex_is_load = 1'b1;
      #1;
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++;
         $display("FAIL same_rs_rt_stall: stall=%b, required 1", stall);
      end
      tick();
      bubble();
      vectors++;
      if (stall_count !== 16'd2) begin
         miscompares++;
         $display("FAIL same_rs_rt_count: cnt=%0d, required 2", stall_count);
      end
      tick();
      tick();
   endtask

   task automatic test_saturation();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      id_rs = 5'd4; id_rt = 5'd0;
      ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4;
      for (int i = 0; i < 20; i++) tick();
      vectors++;
      if (s_count !== 4'd15) begin
         miscompares++;
         $display("FAIL sat_hold: sat_cnt=%0d, required 15", s_count);
      end
      vectors++;
      if (stall_count !== 16'd20) begin
         miscompares++;
         $display("FAIL wide_count: cnt=%0d, required 20", stall_count);
      end
      bubble();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      vectors++;
      if (s_count !== 4'd0 || stall_count !== 16'd0) begin
         miscompares++;
         $display("FAIL sat_reset: sat_cnt=%0d cnt=%0d, required 0 0", s_count, stall_count);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      Reset = 1'b1;
      bubble();
      mem_load_data = 32'h0;
      id_rs = 5'd0; id_rt = 5'd0; PA = 32'h0; PB = 32'h0;
      #1;
      test_reset();
      test_single_write();
      test_forward_chain();
      test_load_use();
      test_r0();
      test_same_operands();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
